// File: rtl/mu0_mem_system.sv
// Mu0 memory subsystem: 4096x16 unified RAM, host program loader, one output
// register at IO_ADDR, and STP (halt) detection with a saturating run-cycle counter.
module mu0_mem_system #(
  parameter int              ADDR        = 12,
  parameter int              DATA        = 16,
  parameter logic [ADDR-1:0] IO_ADDR     = 12'hFFF,
  parameter int              HALT_CYCLES = 4,
  parameter int              RELEASE_DLY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rq,
  input  logic            rnw,
  input  logic [ADDR-1:0] a_out,
  inout  wire  [DATA-1:0] databus,
  output logic            cpu_rst,
  input  logic            ld_start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DATA-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ovf,
  output logic [DATA-1:0] out_data,
  output logic            out_strobe,
  output logic            halted,
  output logic [31:0]     cycle_cnt
);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN, S_HALT} state_e;

  localparam logic [3:0] HALT_N   = 4'(HALT_CYCLES);
  localparam logic [3:0] REL_LAST = 4'(RELEASE_DLY - 1);

  state_e          state_q, state_d;
  logic [ADDR:0]   ld_ptr_q, ld_ptr_d;
  logic            ld_ovf_q, ld_ovf_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic [DATA-1:0] out_data_q, out_data_d;
  logic            out_strobe_q, out_strobe_d;
  logic            halted_q, halted_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic [3:0]      idle_cnt_q, idle_cnt_d;
  logic [3:0]      rel_cnt_q, rel_cnt_d;

  logic [DATA-1:0] mem [2**ADDR];
  logic            mem_we;
  logic [ADDR-1:0] mem_waddr;
  logic [DATA-1:0] mem_wdata;

  logic ld_accept, is_io, cpu_rd, cpu_wr;

  assign ld_ready  = (state_q == S_LOAD) && !ld_ptr_q[ADDR];
  assign ld_accept = ld_valid && ld_ready;
  assign is_io     = (a_out == IO_ADDR);
  assign cpu_rd    = (state_q == S_RUN) && mem_rq && rnw;
  assign cpu_wr    = (state_q == S_RUN) && mem_rq && !rnw;

  // Only a RUN read drives the bus, so the CPU's write drive never contends.
  assign databus = cpu_rd ? (is_io ? out_data_q : mem[a_out]) : 'z;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    ld_ptr_d     = ld_ptr_q;
    ld_ovf_d     = ld_ovf_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    halted_d     = halted_q;
    cycle_cnt_d  = cycle_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = a_out;
    mem_wdata    = databus;

    case (state_q)
      S_LOAD: begin
        if (ld_accept) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q[ADDR-1:0];
          mem_wdata = ld_data;
          ld_ptr_d  = ld_ptr_q + (ADDR+1)'(1);
          if (ld_last) begin
            state_d = S_RELEASE;
          end else if (ld_ptr_d[ADDR]) begin
            ld_ovf_d = 1'b1;
            state_d  = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        rel_cnt_d = rel_cnt_q + 4'd1;
        if (rel_cnt_q == REL_LAST) begin
          rel_cnt_d = 4'd0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (cpu_wr) begin
          if (is_io) begin
            out_data_d   = databus;
            out_strobe_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
        if (mem_rq) begin
          idle_cnt_d = 4'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
          if (idle_cnt_d == HALT_N) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A restart overrides a halt declared in the same cycle; out_data is kept.
    if (ld_start && (state_q == S_RUN || state_q == S_HALT)) begin
      state_d     = S_LOAD;
      ld_ptr_d    = '0;
      ld_ovf_d    = 1'b0;
      halted_d    = 1'b0;
      cycle_cnt_d = '0;
      idle_cnt_d  = '0;
    end

    cpu_rst_d = (state_d == S_LOAD) || (state_d == S_RELEASE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      ld_ptr_q     <= '0;
      ld_ovf_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      halted_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      rel_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ld_ptr_q     <= ld_ptr_d;
      ld_ovf_q     <= ld_ovf_d;
      cpu_rst_q    <= cpu_rst_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      halted_q     <= halted_d;
      cycle_cnt_q  <= cycle_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
    end
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; writes are blocked while rst is held.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign cpu_rst    = cpu_rst_q;
  assign ld_ovf     = ld_ovf_q;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign halted     = halted_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_mu0_mem_system.sv
// Scoreboard bench for mu0_mem_system: a CPU bus model plus a host loader,
// with expected read data and IO-register values queued at drive time.
module tb_mu0_mem_system;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rq, rnw;
  logic [11:0] a_out;
  wire  [15:0] databus;
  logic        cpu_oe;
  logic [15:0] cpu_drv;
  logic        cpu_rst;
  logic        ld_start, ld_valid, ld_ready, ld_last, ld_ovf;
  logic [15:0] ld_data;
  logic [15:0] out_data;
  logic        out_strobe, halted;
  logic [31:0] cycle_cnt;

  assign databus = cpu_oe ? cpu_drv : 16'bz;

  mu0_mem_system dut (
    .clk(clk), .rst(rst), .mem_rq(mem_rq), .rnw(rnw), .a_out(a_out),
    .databus(databus), .cpu_rst(cpu_rst), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ovf(ld_ovf), .out_data(out_data),
    .out_strobe(out_strobe), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] rd_q[$];
  logic [15:0] io_q[$];
  int  run_ticks = 0;
  bit  bench_run = 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    if (bench_run) run_ticks++;
    #1;
  endtask

  task automatic load_word(input logic [15:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tests_run++;
    if (ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL load_ready: got %b want 1", ld_ready);
    end
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a, input logic [15:0] exp);
    logic [15:0] e;
    mem_rq = 1'b1; rnw = 1'b1; a_out = a; cpu_oe = 1'b0;
    rd_q.push_back(exp);
    @(negedge clk);
    e = rd_q.pop_front();
    tests_run++;
    if (databus !== e) begin
      tests_failed++; $display("FAIL read[%h]: got %h want %h", a, databus, e);
    end
    tick();
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
    logic [15:0] e;
    mem_rq = 1'b1; rnw = 1'b0; a_out = a; cpu_oe = 1'b1; cpu_drv = d;
    if (a == 12'hFFF) io_q.push_back(d);
    tick();
    cpu_oe = 1'b0; rnw = 1'b1;
    tests_run++;
    if (out_strobe !== (a == 12'hFFF)) begin
      tests_failed++; $display("FAIL strobe_on_write[%h]: got %b want %b", a, out_strobe, a == 12'hFFF);
    end
    if (a == 12'hFFF) begin
      e = io_q.pop_front();
      tests_run++;
      if (out_data !== e) begin
        tests_failed++; $display("FAIL out_data: got %h want %h", out_data, e);
      end
    end
  endtask

  task automatic idle(input int n);
    mem_rq = 1'b0; cpu_oe = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rq = 1'b0; rnw = 1'b1; a_out = '0; cpu_oe = 1'b0; cpu_drv = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #12;
    tests_run++;
    if ({cpu_rst, ld_ready, ld_ovf, out_strobe, halted} !== 5'b11000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 11000", {cpu_rst, ld_ready, ld_ovf, out_strobe, halted});
    end
    tests_run++;
    if (out_data !== 16'h0 || cycle_cnt !== 32'h0) begin
      tests_failed++; $display("FAIL reset_regs: got %h/%h want 0/0", out_data, cycle_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_load();
    load_word(16'h0005, 1'b0);
    ld_start = 1'b1;
    load_word(16'h1006, 1'b0);
    ld_start = 1'b0;
    load_word(16'h7000, 1'b0);
    load_word(16'h0042, 1'b1);
    tests_run++;
    if (ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      tests_failed++; $display("FAIL release1: got rdy=%b rst=%b want 0/1", ld_ready, cpu_rst);
    end
    tick();
    tests_run++;
    if (cpu_rst !== 1'b1) begin
      tests_failed++; $display("FAIL release2: got cpu_rst=%b want 1", cpu_rst);
    end
    tick();
    tests_run++;
    if (cpu_rst !== 1'b0 || cycle_cnt !== 32'd0) begin
      tests_failed++; $display("FAIL run_entry: got rst=%b cnt=%0d want 0/0", cpu_rst, cycle_cnt);
    end
    bench_run = 1'b1; run_ticks = 0;
  endtask

  task automatic test_read_write();
    cpu_read(12'd3, 16'h0042);
    cpu_read(12'd0, 16'h0005);
    cpu_write(12'd6, 16'hBEEF);
    cpu_read(12'd6, 16'hBEEF);
    cpu_read(12'd2, 16'h7000);
    mem_rq = 1'b0; a_out = 12'd3; cpu_oe = 1'b1; cpu_drv = 16'h0000;
    @(negedge clk);
    tests_run++;
    if (databus !== 16'h0000) begin
      tests_failed++; $display("FAIL bus_release_idle: got %h want 0000", databus);
    end
    tick();
    cpu_oe = 1'b0;
    tests_run++;
    if (cycle_cnt !== 32'(run_ticks) || halted !== 1'b0) begin
      tests_failed++; $display("FAIL run_count: got %0d/%b want %0d/0", cycle_cnt, halted, run_ticks);
    end
  endtask

  task automatic test_io();
    cpu_write(12'hFFF, 16'h1234);
    cpu_read(12'hFFF, 16'h1234);
    tests_run++;
    if (out_strobe !== 1'b0) begin
      tests_failed++; $display("FAIL strobe_single: got %b want 0", out_strobe);
    end
    cpu_write(12'hFFF, 16'h1111);
    cpu_write(12'hFFF, 16'h2222);
    cpu_read(12'hFFF, 16'h2222);
  endtask

  task automatic test_halt();
    idle(3);
    tests_run++;
    if (halted !== 1'b0) begin
      tests_failed++; $display("FAIL halt_early3: got %b want 0", halted);
    end
    cpu_read(12'd0, 16'h0005);
    idle(3);
    tests_run++;
    if (halted !== 1'b0) begin
      tests_failed++; $display("FAIL halt_early_after_rq: got %b want 0", halted);
    end
    idle(1);
    bench_run = 1'b0;
    tests_run++;
    if (halted !== 1'b1 || cycle_cnt !== 32'(run_ticks)) begin
      tests_failed++; $display("FAIL halt_4th: got %b/%0d want 1/%0d", halted, cycle_cnt, run_ticks);
    end
    idle(3);
    tests_run++;
    if (cycle_cnt !== 32'(run_ticks) || halted !== 1'b1 || cpu_rst !== 1'b0 || out_data !== 16'h2222) begin
      tests_failed++; $display("FAIL halt_frozen: got cnt=%0d h=%b rst=%b out=%h want %0d/1/0/2222",
                               cycle_cnt, halted, cpu_rst, out_data, run_ticks);
    end
    mem_rq = 1'b1; rnw = 1'b1; a_out = 12'd3; cpu_oe = 1'b1; cpu_drv = 16'h0000;
    @(negedge clk);
    tests_run++;
    if (databus !== 16'h0000) begin
      tests_failed++; $display("FAIL bus_release_halt: got %h want 0000", databus);
    end
    tick();
    cpu_oe = 1'b0; mem_rq = 1'b0;
  endtask

  task automatic test_overflow();
    int accepted = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    tests_run++;
    if ({cpu_rst, ld_ready, ld_ovf, halted} !== 4'b1100 || cycle_cnt !== 32'd0 || out_data !== 16'h2222) begin
      tests_failed++; $display("FAIL restart_from_halt: got %b cnt=%0d out=%h want 1100/0/2222",
                               {cpu_rst, ld_ready, ld_ovf, halted}, cycle_cnt, out_data);
    end
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < 5000 && ld_ready === 1'b1; i++) begin
      ld_data = 16'(accepted) ^ 16'h5A5A;
      accepted++;
      tick();
    end
    ld_valid = 1'b0;
    tests_run++;
    if (accepted != 4096 || ld_ovf !== 1'b1 || ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      tests_failed++; $display("FAIL overflow: got n=%0d ovf=%b rdy=%b rst=%b want 4096/1/0/1",
                               accepted, ld_ovf, ld_ready, cpu_rst);
    end
    tick(); tick();
    tests_run++;
    if (cpu_rst !== 1'b0 || ld_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL overflow_run: got rst=%b ovf=%b want 0/1", cpu_rst, ld_ovf);
    end
    bench_run = 1'b1; run_ticks = 0;
    cpu_read(12'd7, 16'h5A5D);
    cpu_read(12'hFFE, 16'h55A4);
    cpu_read(12'hFFF, 16'h2222);
    mem_rq = 1'b1; rnw = 1'b0; a_out = 12'hFFF; cpu_oe = 1'b1; cpu_drv = 16'h7777; ld_start = 1'b1;
    tick();
    cpu_oe = 1'b0; ld_start = 1'b0; mem_rq = 1'b0; bench_run = 1'b0;
    tests_run++;
    if ({cpu_rst, ld_ready, ld_ovf, halted} !== 4'b1100 || cycle_cnt !== 32'd0 || out_data !== 16'h7777) begin
      tests_failed++; $display("FAIL restart_from_run: got %b cnt=%0d out=%h want 1100/0/7777",
                               {cpu_rst, ld_ready, ld_ovf, halted}, cycle_cnt, out_data);
    end
  endtask

  task automatic test_async_reset();
    load_word(16'hAAAA, 1'b0);
    load_word(16'hBBBB, 1'b0);
    ld_valid = 1'b1; ld_data = 16'hCCCC;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (cpu_rst !== 1'b1 || out_data !== 16'h0 || halted !== 1'b0 || ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_in_load: got rst=%b out=%h h=%b rdy=%b want 1/0000/0/1",
                               cpu_rst, out_data, halted, ld_ready);
    end
    @(posedge clk); #1 rst = 1'b0; ld_valid = 1'b0;
    load_word(16'h1111, 1'b1);
    tick(); tick();
    cpu_read(12'd1, 16'hBBBB);
    cpu_write(12'hFFF, 16'h4321);
    idle(3);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || cpu_rst !== 1'b1 || out_data !== 16'h4321) begin
      tests_failed++; $display("FAIL start_beats_halt: got h=%b rst=%b out=%h want 0/1/4321", halted, cpu_rst, out_data);
    end
    load_word(16'h2222, 1'b1);
    tick(); tick();
    cpu_write(12'hFFF, 16'h5555);
    mem_rq = 1'b1; rnw = 1'b0; a_out = 12'd1; cpu_oe = 1'b1; cpu_drv = 16'hDEAD;
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (cpu_rst !== 1'b1 || out_data !== 16'h0 || halted !== 1'b0 || cycle_cnt !== 32'd0 || ld_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_in_write: got rst=%b out=%h h=%b cnt=%0d rdy=%b want 1/0000/0/0/1",
                               cpu_rst, out_data, halted, cycle_cnt, ld_ready);
    end
    @(posedge clk); #1 rst = 1'b0; cpu_oe = 1'b0; mem_rq = 1'b0;
    load_word(16'h3333, 1'b1);
    tick(); tick();
    cpu_read(12'd1, 16'hBBBB);
    cpu_read(12'd0, 16'h3333);
  endtask

  initial begin
    test_reset();
    test_load();
    test_read_write();
    test_io();
    test_halt();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mu0_mem_system.md
Name: mu0_mem_system

Overview:
- Memory subsystem directly downstream of the Mu0 processor's memory interface (mem_rq, rnw, a_out, databus).
- Holds a 4096x16 unified program/data RAM with combinational read and synchronous write, matching the CPU's single-cycle access timing.
- Includes a host loader that streams a program image in while holding the CPU in reset, one memory-mapped output register, and STP (halt) detection with a run-cycle counter.

Parameters:
ADDR, 12, CPU address width; RAM depth = 2**ADDR
DATA, 16, data word width
IO_ADDR, 12'hFFF, CPU address decoded as the output register instead of RAM
HALT_CYCLES, 4, consecutive mem_rq=0 cycles in RUN that declare a halt (range 1..15)
RELEASE_DLY, 2, cycles cpu_rst stays high after load completes (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_rq  in  1  CPU memory request
rnw  in  1  CPU read(1)/write(0)
a_out  in  ADDR  CPU address
databus  inout  DATA  shared CPU data bus
cpu_rst  out  1  reset to the CPU, registered
ld_start  in  1  restart load from address 0 (honoured in RUN/HALT)
ld_valid  in  1  loader word valid
ld_ready  out  1  loader can accept a word
ld_data  in  DATA  loader word
ld_last  in  1  qualifies the final word of the image
ld_ovf  out  1  sticky: image filled all 2**ADDR words without ld_last
out_data  out  DATA  memory-mapped output register
out_strobe  out  1  one-cycle pulse on a CPU write to IO_ADDR
halted  out  1  CPU has executed STP
cycle_cnt  out  32  clock cycles spent in RUN, saturating

Behaviour:
- Reset (async, rst=1): state=LOAD, cpu_rst=1, ld_ptr=0, ld_ovf=0, out_data=0, out_strobe=0, halted=0, cycle_cnt=0, idle_cnt=0, rel_cnt=0. RAM contents are not cleared.
- State machine: LOAD -> RELEASE -> RUN -> HALT. ld_start in RUN or HALT returns to LOAD.
- LOAD:
  - cpu_rst=1, ld_ready=1 while ld_ptr<2**ADDR.
  - Handshake: a word is accepted on a posedge with ld_valid&ld_ready. It writes mem[ld_ptr]<=ld_data, then ld_ptr++. ld_ptr is ADDR+1 bits wide.
  - Accepting a word with ld_last=1 moves to RELEASE next cycle.
  - When ld_ptr reaches 2**ADDR without ld_last: ld_ready=0, ld_ovf<=1, move to RELEASE.
  - The loader writes IO_ADDR as ordinary RAM.
- RELEASE: cpu_rst=1 for exactly RELEASE_DLY cycles (rel_cnt counts), then RUN with cpu_rst<=0 registered. ld_ready=0.
- RUN (cpu_rst=0):
  - Read, when mem_rq&rnw: databus driven combinationally with mem[a_out], or out_data if a_out==IO_ADDR. Data is valid within the same cycle so the CPU latches it at the next posedge.
  - Write, when mem_rq&!rnw: databus is not driven by this block. At posedge, mem[a_out]<=databus, or, if a_out==IO_ADDR, out_data<=databus and out_strobe=1 next cycle; RAM is not written in that case.
  - mem_rq=0: no access, databus released.
  - databus is high-Z in every state and condition other than a RUN read, so there is never contention with the CPU's write drive.
  - cycle_cnt increments each RUN cycle and saturates at 32'hFFFF_FFFF.
  - idle_cnt: increments when mem_rq=0, clears to 0 when mem_rq=1. When idle_cnt reaches HALT_CYCLES, go to HALT and set halted<=1.
- HALT: cpu_rst stays 0, halted=1, databus high-Z, cycle_cnt frozen, out_data held.
- ld_start in RUN/HALT: next state LOAD. cpu_rst<=1, ld_ptr<=0, ld_ovf<=0, halted<=0, cycle_cnt<=0, idle_cnt<=0. out_data is retained.
- ld_start is ignored in LOAD and RELEASE.
- Simultaneous events:
  - ld_start has priority over a halt declaration in the same cycle.
  - A CPU write to IO_ADDR in the last RUN cycle before ld_start still updates out_data.
- Reset mid-load or mid-run: asynchronous return to LOAD with the values listed above. A partially loaded image remains in RAM.
- out_strobe is a single-cycle pulse. Back-to-back IO writes give back-to-back pulses.

Test Plan:
- Reset, then load 4 words {16'h0005, 16'h1006, 16'h7000, 16'h0042}, ld_last on the 4th -> ld_ready=0 after the 4th; cpu_rst high exactly 2 cycles in RELEASE, then 0; mem[3]==16'h0042.
- CPU model reads addr 3 in RUN -> databus==16'h0042 in the same cycle; writes 16'hBEEF to addr 6 -> a read of addr 6 returns 16'hBEEF; databus is Z while mem_rq=0.
- CPU write 16'h1234 to 12'hFFF -> out_data==16'h1234, out_strobe high exactly one cycle, RAM[FFF] unchanged; a read of FFF returns 16'h1234.
- mem_rq=0 for 3 cycles, then 1, then 0 for 4 cycles -> halted asserts only after the 4th consecutive idle cycle; cycle_cnt freezes at the RUN cycle count.
- Stream 4096 words without ld_last -> 4096 accepted, ld_ovf=1, ld_ready=0, RELEASE entered; then ld_start in RUN -> LOAD, ld_ovf=0, cycle_cnt=0, cpu_rst=1.
- Assert rst during a CPU write cycle and during load -> cpu_rst=1 immediately (asynchronous), state LOAD, out_data=0, halted=0, no RAM write at the reset edge.
